ram_rd_arbiter: RTL and testbench
=================================

Name: ram_rd_arbiter

Overview:
Shares the single main-RAM read port between two requesters, all on sys_clk:
- Framebuffer fetch (fb): high priority, streaming.
- WS2812 strip engine (st): low priority, bursty.
Applies fixed priority with a starvation guard, drives the registered RAM read strobe and address, and routes returned data to the issuing requester with a tagged valid. Sits between the fetch/shift and strip blocks and the main RAM, replacing their separate read ports.

Parameters:
FB_AW, 14, framebuffer word address width
ST_AW, 7, strip word address width
FB_DW, 20, framebuffer data width (low bits of ram_rdata)
RAM_DW, 80, RAM read data width (strip width)
RAM_LAT, 1, RAM read latency in cycles from ram_re to ram_rdata valid (1..4)
STARVE_MAX, 8, contested cycles strip may wait before it is forced to win one grant
STAT_W, 16, width of statistics counters

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
fb_req  in  1  framebuffer read request; hold with fb_addr until fb_gnt
fb_addr  in  FB_AW  framebuffer word address
fb_gnt  out  1  combinational; request accepted this cycle
fb_rvalid  out  1  fb_rdata valid this cycle
fb_rdata  out  FB_DW  ram_rdata[FB_DW-1:0]
st_req  in  1  strip read request; hold with st_addr until st_gnt
st_addr  in  ST_AW  strip word address
st_gnt  out  1  combinational; request accepted this cycle
st_rvalid  out  1  st_rdata valid this cycle
st_rdata  out  RAM_DW  ram_rdata passthrough
ram_re  out  1  registered RAM read strobe
ram_addr  out  FB_AW+1  registered; MSB=0 framebuffer region {0,fb_addr}, MSB=1 strip region {1,zero-pad,st_addr}
ram_rdata  in  RAM_DW  RAM read data
stat_fb_cnt  out  STAT_W  fb grants, saturating
stat_st_cnt  out  STAT_W  strip grants, saturating
stat_starve_cnt  out  STAT_W  forced strip wins, saturating

Behaviour:
- Reset: all outputs 0, including ram_addr, rvalids, stats, starve counter and tag pipe. Reset mid-read discards in-flight tags; no rvalid follows reset release.
- Handshake: a requester holds req and addr stable until gnt. gnt is high in the same cycle as the accepted req. The requester may present the next address the following cycle, giving one grant per cycle per requester.
- Arbitration, per cycle:
  - only fb_req high: fb wins.
  - only st_req high: st wins.
  - both high: fb wins unless starve_cnt == STARVE_MAX, in which case st wins.
  - STARVE_MAX=0: st wins every contested cycle.
  - Never both gnt in one cycle.
- Starvation counter (width clog2(STARVE_MAX+1)):
  - Increments on each cycle with st_req high and st_gnt low, saturating at STARVE_MAX.
  - Clears on st_gnt or when st_req is low.
- Issue: any grant in cycle N gives ram_re=1 and ram_addr for the winner in N+1. With no grant, ram_re=0 and ram_addr holds its last value.
- Return: a 1-bit tag (0=fb, 1=st) plus a valid bit go through a RAM_LAT-deep shift register launched with ram_re. In cycle N+1+RAM_LAT exactly one of fb_rvalid/st_rvalid pulses per grant. Data outputs are unregistered slices of ram_rdata.
  - Total latency from gnt to rvalid: 1+RAM_LAT cycles.
  - Ordering is preserved per requester and globally.
- No back-pressure on returns; requesters must always accept rvalid.

Optional Feature:
RAM_ARB_STATS_EN
- Defined: the three stat counters increment on fb_gnt, st_gnt, and forced strip wins, saturating at all-ones, cleared only by reset.
- Undefined: the counters are not built and the stat ports are tied to 0.

Decomposition:
- Package hub75_pkg holds:
  - RGN_FB=1'b0, RGN_ST=1'b1 region-select constants.
  - Default widths FB_AW, ST_AW, FB_DW, RAM_DW.
  - Tag typedef rd_tag_t (1 bit).
- One sub-module, arb_tag_pipe: parameterised RAM_LAT-deep valid+tag shift register with async active-low clear. The arbiter instantiates it once.

Test Plan:
- fb_req held 4 cycles with addrs 0x0010..0x0013, st idle:
  - fb_gnt high in all 4 cycles.
  - ram_addr 0x0010..0x0013 one cycle later.
  - fb_rvalid 4 consecutive pulses at RAM_LAT+1 later, data matching a RAM model.
- Both requesting continuously, STARVE_MAX=8:
  - st_gnt once every 9th cycle.
  - stat_starve_cnt increments per forced win.
  - ram_addr MSB=1 only in those issue cycles.
- st_req alone, st_addr=0x45:
  - st_gnt same cycle.
  - ram_addr=0x4045 next cycle.
  - st_rvalid with st_rdata = full 80-bit word; fb_rvalid stays 0.
- Alternating fb/st grants with RAM_LAT=3: return valids follow grant order exactly, each 4 cycles after its gnt.
- rst_n low for 1 cycle while 2 reads are in flight:
  - no rvalid afterwards.
  - ram_re=0 and all outputs 0 during reset.
  - normal grants resume on the first cycle after release.
- Stats with RAM_ARB_STATS_EN defined and STAT_W=4: 20 fb grants leave stat_fb_cnt=15 (saturated). With the macro undefined, the stat ports stay 0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared constants and types for the main-RAM read arbiter: region selects,
// default widths, the return tag type and a counter-width helper.
package hub75_pkg;

  localparam int FB_AW_DEF  = 14;
  localparam int ST_AW_DEF  = 7;
  localparam int FB_DW_DEF  = 20;
  localparam int RAM_DW_DEF = 80;

  localparam logic RGN_FB = 1'b0;
  localparam logic RGN_ST = 1'b1;

  // Return tag: 0 routes data to the framebuffer, 1 to the strip engine.
  typedef logic rd_tag_t;

  function automatic int cnt_w(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/ram_rd_arbiter_if.sv
// Request/grant, return and RAM-port signals shared by the two readers and
// the main RAM; slave is the arbiter side, master is the requester/RAM side.
interface ram_rd_arbiter_if
  import hub75_pkg::*;
#(
  parameter int FB_AW  = FB_AW_DEF,
  parameter int ST_AW  = ST_AW_DEF,
  parameter int FB_DW  = FB_DW_DEF,
  parameter int RAM_DW = RAM_DW_DEF
);
  logic              fb_req;
  logic [FB_AW-1:0]  fb_addr;
  logic              fb_gnt;
  logic              fb_rvalid;
  logic [FB_DW-1:0]  fb_rdata;

  logic              st_req;
  logic [ST_AW-1:0]  st_addr;
  logic              st_gnt;
  logic              st_rvalid;
  logic [RAM_DW-1:0] st_rdata;

  logic              ram_re;
  logic [FB_AW:0]    ram_addr;
  logic [RAM_DW-1:0] ram_rdata;

  modport slave (
    input  fb_req, fb_addr, st_req, st_addr, ram_rdata,
    output fb_gnt, fb_rvalid, fb_rdata, st_gnt, st_rvalid, st_rdata,
           ram_re, ram_addr
  );

  modport master (
    output fb_req, fb_addr, st_req, st_addr, ram_rdata,
    input  fb_gnt, fb_rvalid, fb_rdata, st_gnt, st_rvalid, st_rdata,
           ram_re, ram_addr
  );
endinterface

// File: rtl/arb_tag_pipe.sv
// RAM_LAT-deep valid+tag shift register that follows each RAM read so its
// returning data can be steered to the requester that issued it.
module arb_tag_pipe
  import hub75_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    in_valid,
  input  rd_tag_t in_tag,
  output logic    out_valid,
  output rd_tag_t out_tag
);

  logic    [RAM_LAT-1:0] valid_r;
  rd_tag_t [RAM_LAT-1:0] tag_r;

  // Shift valid and tag together one stage per cycle; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      tag_r   <= '0;
    end else begin
      valid_r[0] <= in_valid;
      tag_r[0]   <= in_tag;
      for (int i = 1; i < RAM_LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        tag_r[i]   <= tag_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[RAM_LAT-1];
  assign out_tag   = tag_r[RAM_LAT-1];

endmodule

// File: rtl/ram_rd_arbiter.sv
// Fixed-priority (framebuffer first) arbiter with a strip starvation guard for
// the shared main-RAM read port. Define RAM_ARB_STATS_EN to build grant counters.
module ram_rd_arbiter
  import hub75_pkg::*;
#(
  parameter int FB_AW      = FB_AW_DEF,
  parameter int ST_AW      = ST_AW_DEF,
  parameter int FB_DW      = FB_DW_DEF,
  parameter int RAM_DW     = RAM_DW_DEF,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 8,
  parameter int STAT_W     = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  ram_rd_arbiter_if.slave   bus,
  output logic [STAT_W-1:0] stat_fb_cnt,
  output logic [STAT_W-1:0] stat_st_cnt,
  output logic [STAT_W-1:0] stat_starve_cnt
);

  localparam int              SC_W       = cnt_w(STARVE_MAX);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  logic            contested_s;
  logic            force_st_s;
  logic            fb_gnt_s;
  logic            st_gnt_s;
  logic [SC_W-1:0] starve_cnt_r;
  logic            ram_re_r;
  logic [FB_AW:0]  ram_addr_r;
  rd_tag_t         issue_tag_r;
  logic            ret_valid_s;
  rd_tag_t         ret_tag_s;

  // Grant decision: framebuffer wins contention unless the strip has waited its limit.
  always_comb begin
    contested_s = bus.fb_req & bus.st_req;
    force_st_s  = contested_s & (starve_cnt_r == STARVE_LIM);
    st_gnt_s    = bus.st_req & (~bus.fb_req | force_st_s);
    fb_gnt_s    = bus.fb_req & ~force_st_s;
  end

  // Count cycles the strip waits; any grant or dropped request restarts the count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= '0;
    end else if (bus.st_req && !st_gnt_s) begin
      if (starve_cnt_r != STARVE_LIM) begin
        starve_cnt_r <= starve_cnt_r + SC_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= '0;
    end
  end

  // Register the RAM strobe, region-mapped address and return tag of the winner.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_re_r    <= 1'b0;
      ram_addr_r  <= '0;
      issue_tag_r <= RGN_FB;
    end else begin
      ram_re_r <= fb_gnt_s | st_gnt_s;
      if (st_gnt_s) begin
        ram_addr_r  <= {RGN_ST, FB_AW'(bus.st_addr)};
        issue_tag_r <= RGN_ST;
      end else if (fb_gnt_s) begin
        ram_addr_r  <= {RGN_FB, bus.fb_addr};
        issue_tag_r <= RGN_FB;
      end else begin
        ram_addr_r  <= ram_addr_r;
        issue_tag_r <= issue_tag_r;
      end
    end
  end

  arb_tag_pipe #(
    .RAM_LAT (RAM_LAT)
  ) u_tag_pipe (
    .clk       (sys_clk),
    .rst_n     (rst_n),
    .in_valid  (ram_re_r),
    .in_tag    (issue_tag_r),
    .out_valid (ret_valid_s),
    .out_tag   (ret_tag_s)
  );

  assign bus.fb_gnt    = fb_gnt_s;
  assign bus.st_gnt    = st_gnt_s;
  assign bus.ram_re    = ram_re_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.fb_rvalid = ret_valid_s & (ret_tag_s == RGN_FB);
  assign bus.st_rvalid = ret_valid_s & (ret_tag_s == RGN_ST);
  assign bus.fb_rdata  = bus.ram_rdata[FB_DW-1:0];
  assign bus.st_rdata  = bus.ram_rdata;

`ifdef RAM_ARB_STATS_EN
  logic [STAT_W-1:0] fb_cnt_r;
  logic [STAT_W-1:0] st_cnt_r;
  logic [STAT_W-1:0] starve_stat_r;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + STAT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Saturating grant statistics, cleared only by reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_cnt_r      <= '0;
      st_cnt_r      <= '0;
      starve_stat_r <= '0;
    end else begin
      fb_cnt_r      <= sat_inc(fb_cnt_r, fb_gnt_s);
      st_cnt_r      <= sat_inc(st_cnt_r, st_gnt_s);
      starve_stat_r <= sat_inc(starve_stat_r, force_st_s);
    end
  end

  assign stat_fb_cnt     = fb_cnt_r;
  assign stat_st_cnt     = st_cnt_r;
  assign stat_starve_cnt = starve_stat_r;
`else
  assign stat_fb_cnt     = '0;
  assign stat_st_cnt     = '0;
  assign stat_starve_cnt = '0;
`endif

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Self-checking bench for ram_rd_arbiter: table-driven grant vectors plus
// contention, mid-flight reset and stat saturation sequences, scoreboarded.
module tb_ram_rd_arbiter;
  import hub75_pkg::*;

  localparam int FB_AW      = 14;
  localparam int ST_AW      = 7;
  localparam int FB_DW      = 20;
  localparam int RAM_DW     = 80;
  localparam int RAM_LAT    = 3;
  localparam int STARVE_MAX = 8;
  localparam int STAT_W     = 4;

`ifdef RAM_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic [STAT_W-1:0] stat_fb_cnt, stat_st_cnt, stat_starve_cnt;

  always #5 sys_clk = ~sys_clk;

  ram_rd_arbiter_if #(.FB_AW(FB_AW), .ST_AW(ST_AW), .FB_DW(FB_DW), .RAM_DW(RAM_DW)) bus ();

  ram_rd_arbiter #(
    .FB_AW(FB_AW), .ST_AW(ST_AW), .FB_DW(FB_DW), .RAM_DW(RAM_DW),
    .RAM_LAT(RAM_LAT), .STARVE_MAX(STARVE_MAX), .STAT_W(STAT_W)
  ) dut (
    .sys_clk         (sys_clk),
    .rst_n           (rst_n),
    .bus             (bus.slave),
    .stat_fb_cnt     (stat_fb_cnt),
    .stat_st_cnt     (stat_st_cnt),
    .stat_starve_cnt (stat_starve_cnt)
  );

  // RAM model: data is a fixed function of the address, RAM_LAT cycles after the read.
  function automatic logic [RAM_DW-1:0] ram_word(input logic [FB_AW:0] a);
    return {a, 5'h11, a ^ 15'h2AAA, 5'h0C, ~a, 5'h07, a ^ 15'h1555, 5'h13};
  endfunction

  logic [FB_AW:0] ram_pipe [RAM_LAT];
  always @(posedge sys_clk) begin
    ram_pipe[0] <= bus.ram_addr;
    for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.ram_rdata = ram_word(ram_pipe[RAM_LAT-1]);

  typedef struct { int due; logic [FB_AW:0] addr; } iss_t;
  typedef struct { int due; logic tag; logic [RAM_DW-1:0] data; } ret_t;
  typedef struct {
    logic fr; logic [FB_AW-1:0] fa; logic sr; logic [ST_AW-1:0] sa; logic efg; logic esg;
  } vec_t;

  iss_t iss_q[$];
  ret_t ret_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [RAM_DW-1:0] act, input logic [RAM_DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle monitor: compares issue and return against the scoreboard queues.
  iss_t iss_e;
  ret_t ret_e;
  always @(posedge sys_clk) begin
    #1;
    cyc = cyc + 1;
    if (!rst_n) begin
      chk("rst_ram_re", bus.ram_re, 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_fb_rvalid", bus.fb_rvalid, 0);
      chk("rst_st_rvalid", bus.st_rvalid, 0);
      chk("rst_stats", {stat_fb_cnt, stat_st_cnt, stat_starve_cnt}, 0);
    end else begin
      if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
        iss_e = iss_q.pop_front();
        chk("issue_re", bus.ram_re, 1);
        chk("issue_addr", bus.ram_addr, iss_e.addr);
      end else begin
        chk("idle_re", bus.ram_re, 0);
      end
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        ret_e = ret_q.pop_front();
        chk("ret_fb_rvalid", bus.fb_rvalid, !ret_e.tag);
        chk("ret_st_rvalid", bus.st_rvalid, ret_e.tag);
        if (ret_e.tag) chk("ret_st_rdata", bus.st_rdata, ret_e.data);
        else chk("ret_fb_rdata", bus.fb_rdata, ret_e.data[FB_DW-1:0]);
      end else begin
        chk("quiet_rvalid", {bus.fb_rvalid, bus.st_rvalid}, 0);
      end
    end
  end

  task automatic drive_check(input logic fr, input logic [FB_AW-1:0] fa, input logic sr,
                             input logic [ST_AW-1:0] sa, input logic efg, input logic esg);
    logic [FB_AW:0] a;
    bus.fb_req = fr; bus.fb_addr = fa; bus.st_req = sr; bus.st_addr = sa;
    #1;
    chk("fb_gnt", bus.fb_gnt, efg);
    chk("st_gnt", bus.st_gnt, esg);
    if (efg) begin
      a = {1'b0, fa};
      iss_q.push_back('{due: cyc + 1, addr: a});
      ret_q.push_back('{due: cyc + 1 + RAM_LAT, tag: 1'b0, data: ram_word(a)});
    end
    if (esg) begin
      a = {1'b1, FB_AW'(sa)};
      iss_q.push_back('{due: cyc + 1, addr: a});
      ret_q.push_back('{due: cyc + 1 + RAM_LAT, tag: 1'b1, data: ram_word(a)});
    end
  endtask

  task automatic step(input logic fr, input logic [FB_AW-1:0] fa, input logic sr,
                      input logic [ST_AW-1:0] sa, input logic efg, input logic esg);
    @(negedge sys_clk);
    drive_check(fr, fa, sr, sa, efg, esg);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[15];
  int   wins;
  int   fb_exp;

  initial begin
    vecs[0]  = '{1'b1, 14'h0010, 1'b0, 7'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 14'h0011, 1'b0, 7'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 14'h0012, 1'b0, 7'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 14'h0013, 1'b0, 7'h00, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 14'h0000, 1'b0, 7'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 14'h0000, 1'b1, 7'h45, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 14'h0000, 1'b0, 7'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 14'h0100, 1'b0, 7'h00, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 14'h0000, 1'b1, 7'h01, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 14'h0101, 1'b0, 7'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 14'h0000, 1'b1, 7'h02, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 14'h0200, 1'b1, 7'h03, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 14'h0201, 1'b1, 7'h03, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 14'h0000, 1'b1, 7'h03, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 14'h0000, 1'b0, 7'h00, 1'b0, 1'b0};

    bus.fb_req = 1'b0; bus.fb_addr = '0; bus.st_req = 1'b0; bus.st_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].fr, vecs[i].fa, vecs[i].sr, vecs[i].sa, vecs[i].efg, vecs[i].esg);
    idle(RAM_LAT + 2);

    // Continuous contention: strip is forced through on every 9th cycle.
    wins = 0;
    for (int i = 0; i < 27; i++) begin
      step(1'b1, FB_AW'(14'h0300 + i), 1'b1, ST_AW'(7'h10 + wins),
           (i % 9) != 8, (i % 9) == 8);
      chk("starve_stat_run", stat_starve_cnt, STATS_ON ? STAT_W'(wins) : '0);
      if ((i % 9) == 8) wins++;
    end
    idle(1);
    chk("starve_stat_total", stat_starve_cnt, STATS_ON ? STAT_W'(3) : '0);
    chk("st_stat_total", stat_st_cnt, STATS_ON ? STAT_W'(7) : '0);
    chk("fb_stat_sat_early", stat_fb_cnt, STATS_ON ? STAT_W'(15) : '0);
    idle(RAM_LAT + 2);

    // Reset for one cycle while two framebuffer reads are in flight.
    step(1'b1, 14'h0400, 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 14'h0401, 1'b0, '0, 1'b1, 1'b0);
    @(negedge sys_clk);
    bus.fb_req = 1'b0; bus.st_req = 1'b0;
    rst_n = 1'b0;
    ret_q.delete();
    iss_q.delete();
    #1;
    chk("rst_async_re", bus.ram_re, 0);
    chk("rst_async_addr", bus.ram_addr, 0);
    chk("rst_async_stats", {stat_fb_cnt, stat_st_cnt, stat_starve_cnt}, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    drive_check(1'b1, 14'h0500, 1'b0, '0, 1'b1, 1'b0);

    // Twenty more framebuffer grants saturate the 4-bit counter.
    fb_exp = 1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, FB_AW'(14'h0600 + i), 1'b0, '0, 1'b1, 1'b0);
      fb_exp++;
    end
    idle(RAM_LAT + 2);
    chk("fb_stat_sat", stat_fb_cnt, STATS_ON ? STAT_W'(fb_exp > 15 ? 15 : fb_exp) : '0);
    chk("st_stat_after_rst", stat_st_cnt, 0);
    chk("starve_stat_after_rst", stat_starve_cnt, 0);
    chk("sb_ret_drained", ret_q.size(), 0);
    chk("sb_iss_drained", iss_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
